// File: rtl/alu_ctrl_defs.sv
// alu_ctrl_defs: shared ALU control codes and the multiply sequencer state encoding.
// The pipeline EX stage, the ALU and mul_seq_ctrl all use the same 4-bit ALU codes.
package alu_ctrl_defs;

   localparam logic [3:0] AluAnd   = 4'b0000;
   localparam logic [3:0] AluOr    = 4'b0001;
   localparam logic [3:0] AluAdd   = 4'b0010;
   localparam logic [3:0] AluLsl   = 4'b0011;
   localparam logic [3:0] AluLsr   = 4'b0100;
   localparam logic [3:0] AluSub   = 4'b0110;
   localparam logic [3:0] AluPassB = 4'b0111;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: arbiter for the shared EX-stage ALU plus an iterative shift-add multiplier.
// Normally the pipeline's EX request passes straight through to the ALU. An accepted MUL
// takes the ALU for one ADD per cycle until the remaining multiplier bits are zero, then
// returns the low N bits of the product with a one-cycle done pulse.
//
// Ports:
//   CLK, Reset_L                    clock (rising edge), synchronous active-low reset
//   ex_ALUCtrl/ex_BusA/ex_BusB      pipeline EX request
//   alu_ALUCtrl/alu_BusA/alu_BusB   drive to the shared ALU
//   alu_BusW                        ALU result (combinational)
//   mul_req/mul_a/mul_b             multiply request and operands
//   mul_ready                       a request can be accepted this cycle
//   mul_done/mul_result             one-cycle done pulse and product (held until replaced)
//   stall                           hold the pipeline EX stage
module mul_seq_ctrl
   import alu_ctrl_defs::*;
#(
   parameter int unsigned N     = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic [3:0]       ex_ALUCtrl,
   input  logic [N-1:0]     ex_BusA,
   input  logic [N-1:0]     ex_BusB,
   output logic [3:0]       alu_ALUCtrl,
   output logic [N-1:0]     alu_BusA,
   output logic [N-1:0]     alu_BusB,
   input  logic [N-1:0]     alu_BusW,
   input  logic             mul_req,
   input  logic [N-1:0]     mul_a,
   input  logic [N-1:0]     mul_b,
   output logic             mul_ready,
   output logic             mul_done,
   output logic [N-1:0]     mul_result,
   output logic             stall
);

   mul_state_e         r_state;
   logic [N-1:0]       r_prod;
   logic [N-1:0]       r_mcand;
   logic [N-1:0]       r_mplr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_done;
   logic [N-1:0]       r_result;

   logic               w_run;
   logic [N-1:0]       w_mplr_next;
   logic               w_last_iter;

   assign w_run       = (r_state == StRun);
   assign w_mplr_next = r_mplr >> 1;
   // Stop early once no multiplier bits remain; the count bound covers the top bit.
   assign w_last_iter = (w_mplr_next == '0) || (r_cnt == CNT_W'(N - 1));

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         r_state  <= StIdle;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_cnt    <= '0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (mul_req) begin
                  r_mcand <= mul_a;
                  r_mplr  <= mul_b;
                  r_prod  <= '0;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  if (mul_b != '0) begin
                     r_state <= StRun;
                  end else begin
                     // Zero multiplier: product is known, skip straight to DONE.
                     r_state  <= StDone;
                     r_done   <= 1'b1;
                     r_result <= '0;
                  end
               end
            end
            StRun: begin
               r_prod  <= alu_BusW;
               r_mcand <= r_mcand << 1;
               r_mplr  <= w_mplr_next;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last_iter) begin
                  r_state  <= StDone;
                  r_done   <= 1'b1;
                  // Loaded on entry to DONE so the result is valid alongside the pulse.
                  r_result <= alu_BusW;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= StIdle;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // ALU ownership: ADD of partial product and gated multiplicand in RUN, else pass-through.
   always_comb begin
      alu_ALUCtrl = ex_ALUCtrl;
      alu_BusA    = ex_BusA;
      alu_BusB    = ex_BusB;
      if (w_run) begin
         alu_ALUCtrl = AluAdd;
         alu_BusA    = r_prod;
         alu_BusB    = r_mplr[0] ? r_mcand : '0;
      end
   end

   assign mul_ready  = r_ready;
   assign mul_done   = r_done;
   assign mul_result = r_result;
   assign stall      = ((r_state == StIdle) && mul_req) || w_run;

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer and arbiter for the shared 64-bit EX-stage ALU. It owns the ALU's operand and control inputs and normally passes the pipeline's EX request straight through. When a MUL is accepted, it stalls the pipeline and takes the ALU for an iterative shift-add multiply, one ALU ADD per cycle. The low 64 bits of the product are returned with a one-cycle done pulse.

## Interface
Parameters:
- N, 64, datapath width
- CNT_W, 7, iteration counter width (holds 0..N)

Ports:
- CLK  in  1  clock, rising edge
- Reset_L  in  1  reset, synchronous, active-low
- ex_ALUCtrl  in  4  pipeline EX ALU control
- ex_BusA  in  N  pipeline EX operand A
- ex_BusB  in  N  pipeline EX operand B
- alu_ALUCtrl  out  4  to ALU control
- alu_BusA  out  N  to ALU operand A
- alu_BusB  out  N  to ALU operand B
- alu_BusW  in  N  ALU result (combinational, settles within one cycle)
- mul_req  in  1  multiply request
- mul_a  in  N  multiplicand
- mul_b  in  N  multiplier
- mul_ready  out  1  high when a request can be accepted
- mul_done  out  1  one-cycle pulse, mul_result valid
- mul_result  out  N  product, low N bits
- stall  out  1  hold the pipeline EX stage

## Operation
- States:
  - IDLE: ALU pass-through, mul_ready=1.
  - RUN: the block owns the ALU.
  - DONE: ALU pass-through, mul_done=1.
- Accept: mul_req & mul_ready at a rising edge.
  - Capture mcand<=mul_a, mplr<=mul_b, prod<=0, cnt<=0.
  - Next state is RUN if mul_b!=0, else DONE.
- RUN cycle ALU drive:
  - alu_ALUCtrl=4'b0010 (ADD).
  - alu_BusA=prod.
  - alu_BusB = mplr[0] ? mcand : 0.
- RUN cycle edge updates:
  - prod<=alu_BusW, mcand<=mcand<<1 (local shift), mplr<=mplr>>1, cnt<=cnt+1.
  - If (mplr>>1)==0 or cnt==N-1, go to DONE.
- DONE: mul_result<=prod (registered, held until the next accept), then go to IDLE.
- Pass-through (IDLE, DONE): alu_* = ex_* combinationally.
- stall = (IDLE & mul_req) | RUN. It is low in DONE, so the pipeline advances and captures mul_result that cycle.
- Arithmetic: all adds are modulo 2^N and overflow is discarded. Operands are treated as unsigned; the low N bits are identical for signed operands.
- mul_req while mul_ready=0 (RUN, DONE) is ignored and not queued. The requester holds mul_req until accepted.
- Operand changes after accept have no effect.
- Reset_L=0 at an edge, in any state including mid-RUN:
  - state returns to IDLE.
  - prod, mcand, mplr, cnt and mul_result return to 0.
  - mul_done returns to 0.
  - Outputs return to their reset values on the next cycle.

## Timing
- Reset values:
  - mul_ready=1, mul_done=0, mul_result=0, stall=mul_req (combinational).
  - alu_* = ex_* (pass-through).
- Latency: with k = index of the highest set bit of mul_b plus 1 (k=0 for mul_b=0), mul_done is high in the cycle after k RUN cycles. That is k+1 cycles after the accept edge.
  - Maximum: 64 RUN cycles + 1 DONE cycle.
- Throughput: the next accept is possible in the IDLE cycle after DONE. Minimum spacing between accepts is k+2 cycles.
- mul_ready, mul_done and the RUN-state ALU drive are decoded from registered state only.
- stall and the pass-through mux are combinational from registered state and inputs.
- Clock period must exceed the ALU settle time. The bench uses 50 ns.

## Structure
- Shared package/header `alu_ctrl_defs`:
  - ALU control codes: AND 0000, OR 0001, ADD 0010, LSL 0011, LSR 0100, SUB 0110, PASSB 0111.
  - State encoding: IDLE, RUN, DONE.
  - The ALU and pipeline reuse the same codes.
- No sub-module. The ALU is instantiated at the CPU top and wired to alu_*/alu_BusW. The pass-through mux and the FSM live in this block.

## Test plan
- Reset mid-multiply:
  - Stimulus: accept 5×0xFF, drop Reset_L for 1 edge during the 3rd RUN cycle.
  - Required: next cycle IDLE, mul_ready=1, mul_result=0, no mul_done pulse.
- Small multiply:
  - Stimulus: mul_a=7, mul_b=6.
  - Required: 3 RUN cycles with alu_ALUCtrl=0010 and alu_BusB = 0, 14, 28; mul_done on the 4th cycle after accept; mul_result=42; stall low in the DONE cycle.
- Zero multiplier:
  - Stimulus: mul_a=0xDEAD, mul_b=0.
  - Required: no RUN cycles, mul_done the cycle after accept, mul_result=0, alu_* mirror ex_* throughout.
- Full width with overflow:
  - Stimulus: mul_a=0xFFFF_FFFF_FFFF_FFFF, mul_b=0x8000_0000_0000_0000.
  - Required: 64 RUN cycles; mul_result=0x8000_0000_0000_0000.
- Pass-through and arbitration:
  - Stimulus: in IDLE set ex_ALUCtrl=0110, ex_BusA=10, ex_BusB=3; then accept a MUL.
  - Required: in IDLE alu_* mirror ex_* and alu_BusW=7. During RUN, alu_ALUCtrl=0010 regardless of ex_*, stall=1, and a second mul_req is ignored.
- Back-to-back:
  - Stimulus: mul_req held high with 3×3, then 4×4.
  - Required: results 9 then 16. The second accept happens in the IDLE cycle following the first DONE.
